dct_transpose_buffer: RTL and testbench

Row-to-column transpose buffer placed directly downstream of the 1-D DCT-II top level. It collects the N coefficient rows of an NxN block (N = 4, 8, 16 or 32) in the 512-bit packed format that the 1-D stage produces. It then re-emits the block column by column in the same packed format, so that a second 1-D DCT pass can consume the columns and complete the 2-D transform. Valid/ready handshakes sit on both sides.

---
 rtl/dct_pkg.sv | 32 +++
 rtl/dct_transpose_buffer_bank.sv | 39 +++
 rtl/dct_transpose_buffer.sv | 109 ++++++++++
 tb/tb_dct_transpose_buffer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Shared types and constants for the DCT transpose datapath.
// No logic: types, widths and the size-code decode only.
// Backpressure is not applicable to a package.
package dct_pkg;

  localparam int DW   = 16;
  localparam int NMAX = 32;

  // Block size code, same encoding as the 1-D DCT stage.
  typedef enum logic [1:0] {
    SZ4  = 2'b00,
    SZ8  = 2'b01,
    SZ16 = 2'b10,
    SZ32 = 2'b11
  } size_t;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Block dimension n for a size code.
  function automatic logic [5:0] size_to_n(size_t s);
    case (s)
      SZ4:     return 6'd4;
      SZ8:     return 6'd8;
      SZ16:    return 6'd16;
      default: return 6'd32;
    endcase
  endfunction

endpackage

// File: rtl/dct_transpose_buffer_bank.sv
// Purpose: NMAX x NMAX coefficient store, row write port and column read port.
// Latency: write lands on the clock edge; column read is combinational from the store.
// Backpressure: none, the parent decides when to write and which column to read.
module tb_bank #(
  parameter int DW   = 16,
  parameter int NMAX = 32
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [4:0]             wr_row,
  input  logic [0:NMAX*DW-1]     wr_dat,
  input  logic [5:0]             wr_n,
  input  logic [4:0]             rd_col,
  output logic [0:NMAX*DW-1]     rd_dat
);

  // Contents are deliberately not reset: every block rewrites rows 0..n-1 before reading.
  logic [DW-1:0] mem [NMAX][NMAX];

  // Write elements 0..n-1 of the incoming row; elements at or beyond n are dropped.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < NMAX; k++) begin
        if (6'(k) < wr_n) begin
          mem[wr_row][k] <= wr_dat[k*DW +: DW];
        end
      end
    end
  end

  // Gather column rd_col: element k of the output comes from stored row k.
  always_comb begin
    rd_dat = '0;
    for (int k = 0; k < NMAX; k++) begin
      rd_dat[k*DW +: DW] = mem[k][rd_col];
    end
  end

endmodule

// File: rtl/dct_transpose_buffer.sv
// Purpose: collect n rows of an n x n coefficient block, then re-emit it column by column.
// Latency: column 0 is presented the cycle after the last row is accepted.
// Backpressure: in_ready is low for the whole drain; out_ready low stalls and holds all outputs.
module dct_transpose_buffer
  import dct_pkg::*;
#(
  parameter int DW   = dct_pkg::DW,
  parameter int NMAX = dct_pkg::NMAX
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [0:NMAX*DW-1]     in_row,
  input  logic [1:0]             in_size,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [0:NMAX*DW-1]     out_col,
  output logic [1:0]             out_size,
  output logic [4:0]             out_idx,
  output logic                   out_last
);

  state_t             state;
  logic [4:0]         row_q;
  logic [4:0]         col_q;
  size_t              size_q;
  logic [5:0]         n_wr;
  logic [5:0]         n_rd;
  logic               wr_en;
  logic               last_col;
  logic [0:NMAX*DW-1] rd_col;

  // Row 0 carries the size for the block; later rows use the latched value.
  assign n_wr     = (row_q == 5'd0) ? size_to_n(size_t'(in_size)) : size_to_n(size_q);
  assign n_rd     = size_to_n(size_q);
  assign wr_en    = (state == FILL) && in_valid;
  assign last_col = ({1'b0, col_q} == (n_rd - 6'd1));

  tb_bank #(
    .DW   (DW),
    .NMAX (NMAX)
  ) u_bank (
    .clk    (clk),
    .we     (wr_en),
    .wr_row (row_q),
    .wr_dat (in_row),
    .wr_n   (n_wr),
    .rd_col (col_q),
    .rd_dat (rd_col)
  );

  // Fill/drain sequencing with row and column counters and the size latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FILL;
      row_q  <= 5'd0;
      col_q  <= 5'd0;
      size_q <= SZ4;
    end else begin
      case (state)
        FILL: begin
          if (in_valid) begin
            if (row_q == 5'd0) begin
              size_q <= size_t'(in_size);
            end
            if ({1'b0, row_q} == (n_wr - 6'd1)) begin
              state <= DRAIN;
              row_q <= 5'd0;
              col_q <= 5'd0;
            end else begin
              row_q <= row_q + 5'd1;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (last_col) begin
              state <= FILL;
              col_q <= 5'd0;
            end else begin
              col_q <= col_q + 5'd1;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  assign in_ready  = (state == FILL);
  assign out_valid = (state == DRAIN);
  assign out_idx   = col_q;
  assign out_size  = size_q;
  assign out_last  = (state == DRAIN) && last_col;

  // Present the column only while draining, zeroing elements outside the block.
  always_comb begin
    out_col = '0;
    if (state == DRAIN) begin
      for (int k = 0; k < NMAX; k++) begin
        if (6'(k) < n_rd) begin
          out_col[k*DW +: DW] = rd_col[k*DW +: DW];
        end
      end
    end
  end

endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Bench for dct_transpose_buffer: queue-based transpose model plus literal spot values.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
// The model derives readiness and expected columns from block-level rules only.
module tb_dct_transpose_buffer;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [0:511] in_row;
  logic [1:0]   in_size;
  logic         out_valid;
  logic         out_ready;
  logic [0:511] out_col;
  logic [1:0]   out_size;
  logic [4:0]   out_idx;
  logic         out_last;

  always #5 clk = ~clk;

  dct_transpose_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .in_size   (in_size),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_col   (out_col),
    .out_size  (out_size),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  typedef struct {
    logic [0:511] col;
    logic [4:0]   idx;
    logic         last;
    logic [1:0]   size;
  } exp_t;

  exp_t         q[$];
  exp_t         m_e;
  logic [0:511] m_c;
  logic [0:511] mrow [32];
  int           got = 0;
  int           blk_n = 4;
  logic [1:0]   blk_sz = 2'b00;
  int           n_cmp = 0;
  int           n_bad = 0;
  int           low_cnt = 0;
  bit           chk_en = 1'b0;
  logic [0:511] row;

  function automatic void check(string name, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endfunction

  function automatic void check_w(string name, logic [0:511] act, logic [0:511] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  function automatic int dim(logic [1:0] s);
    return 4 << s;
  endfunction

  function automatic int el(logic [0:511] w, int k);
    return int'(w[k*16 +: 16]);
  endfunction

  // Model: buffer accepted rows; once a block is complete, queue its n transposed columns.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      got = 0;
    end else if (q.size() != 0) begin
      if (out_ready) m_e = q.pop_front();
    end else if (in_valid) begin
      if (got == 0) begin
        blk_n  = dim(in_size);
        blk_sz = in_size;
      end
      mrow[got] = in_row;
      got++;
      if (got == blk_n) begin
        for (int cc = 0; cc < blk_n; cc++) begin
          m_c = '0;
          for (int k = 0; k < blk_n; k++) m_c[k*16 +: 16] = mrow[k][cc*16 +: 16];
          m_e.col  = m_c;
          m_e.idx  = 5'(cc);
          m_e.last = (cc == blk_n - 1);
          m_e.size = blk_sz;
          q.push_back(m_e);
        end
        got = 0;
      end
    end
  end

  // Compare every cycle against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 32'(in_ready), 32'(q.size() == 0));
      check("out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        check_w("out_col", out_col, q[0].col);
        check("out_idx", 32'(out_idx), 32'(q[0].idx));
        check("out_last", 32'(out_last), 32'(q[0].last));
        check("out_size", 32'(out_size), 32'(q[0].size));
      end else begin
        check_w("out_col_idle", out_col, '0);
      end
      if (!in_ready) low_cnt++;
    end
  end

  task automatic send_row(input logic [0:511] r, input logic [1:0] sz);
    bit took;
    in_valid = 1'b1;
    in_row   = r;
    in_size  = sz;
    for (int i = 0; i < 200; i++) begin
      took = in_ready;
      @(posedge clk);
      #1;
      if (took) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL send_row: row not accepted within 200 cycles");
  endtask

  task automatic drain(input logic [0:3] pat);
    for (int i = 0; i < 500; i++) begin
      out_ready = pat[i % 4];
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        out_ready = 1'b0;
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL drain: block not drained within 500 cycles");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 1);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check_w({tag, "_out_col"}, out_col, '0);
    check({tag, "_out_idx"}, 32'(out_idx), 0);
    check({tag, "_out_last"}, 32'(out_last), 0);
    check({tag, "_out_size"}, 32'(out_size), 0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_row    = '0;
    in_size   = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_outputs("reset");
    chk_en = 1'b1;

    // 4x4: element k of row r = 16r+k; column c element k must be 16k+c.
    low_cnt = 0;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 32; k++) row[k*16 +: 16] = 16'(16*r + k);
      send_row(row, 2'b00);
    end
    in_valid = 1'b0;
    check("t4_c0_e1", el(out_col, 1), 16);
    check("t4_c0_e3", el(out_col, 3), 48);
    check("t4_c0_e4", el(out_col, 4), 0);
    check("t4_model_c3_last", 32'(q[3].last), 1);
    check("t4_model_c3_e2", el(q[3].col, 2), 35);
    drain(4'b1111);
    check("t4_ready_low", low_cnt, 4);

    // 32x32, no stalls, odd rows carry negative values 0x8000|k.
    low_cnt = 0;
    for (int r = 0; r < 32; r++) begin
      for (int k = 0; k < 32; k++)
        row[k*16 +: 16] = (r % 2 == 1) ? (16'h8000 | 16'(k)) : 16'(r*32 + k);
      send_row(row, 2'b11);
    end
    in_valid = 1'b0;
    check("t32_c0_e1", el(out_col, 1), 32'h8000);
    check("t32_c0_e2", el(out_col, 2), 64);
    check("t32_c0_e31", el(out_col, 31), 32'h8000);
    check("t32_model_c5_e1", el(q[5].col, 1), 32'h8005);
    drain(4'b1111);
    check("t32_ready_low", low_cnt, 32);

    // 8x8 with out_ready 1,0,0,1 repeating: 8 transfers need 16 cycles.
    low_cnt = 0;
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 32; k++) row[k*16 +: 16] = 16'(256*r + k);
      send_row(row, 2'b01);
    end
    in_valid = 1'b0;
    drain(4'b1001);
    check("t8bp_ready_low", low_cnt, 16);

    // Size only taken from row 0; in_valid held high with junk through the drain.
    low_cnt = 0;
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 32; k++) row[k*16 +: 16] = (k < 8) ? 16'(r*8 + k + 64) : 16'h7777;
      send_row(row, (r == 0) ? 2'b01 : 2'b11);
    end
    in_row = {32{16'hABCD}};
    check("tsz_c0_e1", el(out_col, 1), 72);
    check("tsz_c0_e8", el(out_col, 8), 0);
    check("tsz_out_size", 32'(out_size), 1);
    drain(4'b1111);
    in_valid = 1'b0;
    check("tsz_ready_low", low_cnt, 8);

    // Reset during drain of a 16x16 block after column 2 has been taken.
    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < 32; k++) row[k*16 +: 16] = 16'(r*16 + k + 16'h2000);
      send_row(row, 2'b10);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("trst_idx_before", 32'(out_idx), 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("midrst");
    rst       = 1'b0;
    out_ready = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 32; k++) row[k*16 +: 16] = 16'(r*16 + k + 16'h0300);
      send_row(row, 2'b00);
    end
    in_valid = 1'b0;
    check("trst_c0_e2", el(out_col, 2), 32'h0320);
    drain(4'b1111);

    // Back-to-back 16x16 then 8x8 with in_valid kept high.
    low_cnt   = 0;
    out_ready = 1'b1;
    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < 32; k++) row[k*16 +: 16] = 16'(r*16 + k + 16'h1000);
      send_row(row, 2'b10);
    end
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 32; k++) row[k*16 +: 16] = 16'(16'hF000 - r*8 - k);
      send_row(row, 2'b01);
    end
    in_valid = 1'b0;
    check("tb2b_c0_e1", el(out_col, 1), 32'hEFF8);
    drain(4'b1111);
    check("tb2b_ready_low", low_cnt, 24);

    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
